// File: rtl/sq_ctrl_pkg.sv
// sq_ctrl_pkg: shared store-queue types, depth and wrap-flag pointer helper
package sq_ctrl_pkg;

    localparam int SQ_DEPTH = 8;
    localparam int SQ_PTR_W = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} sq_state_t;

    typedef struct packed {
        logic                flag;
        logic [SQ_PTR_W-1:0] idx;
    } sq_ptr_t;

    function automatic sq_ptr_t sq_ptr_inc(input sq_ptr_t p);
        return (p.idx == SQ_PTR_W'(SQ_DEPTH - 1)) ? sq_ptr_t'{~p.flag, '0}
                                                  : sq_ptr_t'{p.flag, p.idx + 1'b1};
    endfunction

endpackage

// File: rtl/sq_ctrl_if.sv
// sq_ctrl_if: dispatch, commit, dcache issue and flush signals of the store queue controller
interface sq_ctrl_if #(
    parameter int SQ_DEPTH = sq_ctrl_pkg::SQ_DEPTH,
    parameter int SQ_PTR_W = $clog2(SQ_DEPTH)
);

    logic                disp_valid;
    logic                disp_ready;
    logic [SQ_DEPTH-1:0] enq_onehot;
    logic [SQ_PTR_W:0]   enq_sqidx;
    logic                commit_valid;
    logic [SQ_DEPTH-1:0] commit_onehot;
    logic [SQ_DEPTH-1:0] entry_ready_to_go;
    logic                dcache_req_valid;
    logic                dcache_req_ready;
    logic [SQ_PTR_W-1:0] dcache_req_sel;
    logic [SQ_DEPTH-1:0] issuing_onehot;
    logic                flush_req;
    logic                entry_flush;
    logic [SQ_PTR_W:0]   sq_count;
    logic                sq_empty;

    modport master (
        output disp_valid, commit_valid, entry_ready_to_go, dcache_req_ready, flush_req,
        input  disp_ready, enq_onehot, enq_sqidx, commit_onehot, dcache_req_valid,
               dcache_req_sel, issuing_onehot, entry_flush, sq_count, sq_empty
    );

    modport slave (
        input  disp_valid, commit_valid, entry_ready_to_go, dcache_req_ready, flush_req,
        output disp_ready, enq_onehot, enq_sqidx, commit_onehot, dcache_req_valid,
               dcache_req_sel, issuing_onehot, entry_flush, sq_count, sq_empty
    );

endinterface

// File: rtl/sq_ptr.sv
// sq_ptr: {wrap flag, index} queue pointer with increment and synchronous clear
module sq_ptr import sq_ctrl_pkg::*; (
    input  logic    clock,
    input  logic    reset,
    input  logic    inc,
    input  logic    clr,
    output sq_ptr_t ptr
);

    // Clear wins over increment so a flush always lands the pointer on zero.
    always_ff @(posedge clock or posedge reset)
        if (reset) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= sq_ptr_inc(ptr);

endmodule

// File: rtl/sq_ctrl.sv
// sq_ctrl: store queue pointer control -- allocation, commit marking, in-order dcache issue, flush
module sq_ctrl import sq_ctrl_pkg::*; #(
    parameter int SQ_DEPTH = sq_ctrl_pkg::SQ_DEPTH,
    parameter int SQ_PTR_W = $clog2(SQ_DEPTH)
) (
    input logic     clock,
    input logic     reset,
    sq_ctrl_if.slave bus
);

    sq_state_t state;
    sq_ptr_t   enq_ptr, cmt_ptr, deq_ptr, cmt_nxt, deq_nxt;
    logic      full, ptr_clr, enq_fire, cmt_fire, iss_fire;

    assign ptr_clr = (state == FLUSH);

    sq_ptr u_enq (.clock(clock), .reset(reset), .inc(enq_fire), .clr(ptr_clr), .ptr(enq_ptr));
    sq_ptr u_cmt (.clock(clock), .reset(reset), .inc(cmt_fire), .clr(ptr_clr), .ptr(cmt_ptr));
    sq_ptr u_deq (.clock(clock), .reset(reset), .inc(iss_fire), .clr(ptr_clr), .ptr(deq_ptr));

    // Handshakes and strobes; reset gates the input-driven strobes so nothing fires while held.
    always_comb begin
        full                 = (enq_ptr.idx == deq_ptr.idx) && (enq_ptr.flag != deq_ptr.flag);
        bus.disp_ready       = !reset && (state == RUN) && !full && !bus.flush_req;
        enq_fire             = bus.disp_valid && bus.disp_ready;
        cmt_fire             = !reset && (state == RUN) && bus.commit_valid;
        bus.dcache_req_valid = bus.entry_ready_to_go[deq_ptr.idx] && (deq_ptr != cmt_ptr);
        iss_fire             = bus.dcache_req_valid && bus.dcache_req_ready;
        bus.enq_onehot       = enq_fire ? SQ_DEPTH'(1) << enq_ptr.idx : '0;
        bus.enq_sqidx        = (SQ_PTR_W + 1)'(enq_ptr);
        bus.commit_onehot    = cmt_fire ? SQ_DEPTH'(1) << cmt_ptr.idx : '0;
        bus.issuing_onehot   = iss_fire ? SQ_DEPTH'(1) << deq_ptr.idx : '0;
        bus.dcache_req_sel   = deq_ptr.idx;
        bus.sq_count         = enq_ptr - deq_ptr;
        bus.sq_empty         = (enq_ptr == deq_ptr);
        cmt_nxt              = cmt_fire ? sq_ptr_inc(cmt_ptr) : cmt_ptr;
        deq_nxt              = iss_fire ? sq_ptr_inc(deq_ptr) : deq_ptr;
    end

    // Flush sequencing: drain committed stores to the dcache, then clear every pointer for one cycle.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state           <= RUN;
            bus.entry_flush <= 1'b0;
        end else begin
            unique case (state)
                RUN:     if (bus.flush_req) state <= (cmt_nxt == deq_nxt) ? FLUSH : DRAIN;
                DRAIN:   if (deq_nxt == cmt_ptr) state <= FLUSH;
                default: state <= RUN;
            endcase
            bus.entry_flush <= ((state == RUN) && bus.flush_req && (cmt_nxt == deq_nxt)) ||
                               ((state == DRAIN) && (deq_nxt == cmt_ptr));
        end

    // The ROB may only retire a store that has been dispatched.
    a_commit_legal: assert property (@(posedge clock) disable iff (reset)
        ((state == RUN) && bus.commit_valid) |-> (cmt_ptr != enq_ptr));

endmodule

// File: tb/tb_sq_ctrl.sv
// tb_sq_ctrl: directed scenarios plus random traffic checked against a sequence-count model
module tb_sq_ctrl;

    localparam int DEPTH   = 8;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_FLUSH = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sq_ctrl_if #(.SQ_DEPTH(DEPTH)) bus ();
    sq_ctrl #(.SQ_DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    int n_chk = 0;
    int n_fail = 0;
    int e, c, d, mode;
    bit efire, cfire, ifire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        bit rdy, dval;
        if (reset) begin
            e = 0; c = 0; d = 0; mode = M_RUN;
        end
        rdy   = !reset && mode == M_RUN && (e - d) != DEPTH && !bus.flush_req;
        efire = rdy && bus.disp_valid;
        cfire = !reset && mode == M_RUN && bus.commit_valid;
        dval  = (d < c) && bus.entry_ready_to_go[d % DEPTH];
        ifire = dval && bus.dcache_req_ready;
        chk("disp_ready", 32'(bus.disp_ready), 32'(rdy));
        chk("enq_onehot", 32'(bus.enq_onehot), efire ? 32'(1) << (e % DEPTH) : 32'(0));
        chk("enq_sqidx", 32'(bus.enq_sqidx), 32'(e % (2 * DEPTH)));
        chk("commit_onehot", 32'(bus.commit_onehot), cfire ? 32'(1) << (c % DEPTH) : 32'(0));
        chk("dcache_req_valid", 32'(bus.dcache_req_valid), 32'(dval));
        chk("dcache_req_sel", 32'(bus.dcache_req_sel), 32'(d % DEPTH));
        chk("issuing_onehot", 32'(bus.issuing_onehot), ifire ? 32'(1) << (d % DEPTH) : 32'(0));
        chk("entry_flush", 32'(bus.entry_flush), 32'(mode == M_FLUSH));
        chk("sq_count", 32'(bus.sq_count), 32'(e - d));
        chk("sq_empty", 32'(bus.sq_empty), 32'(e == d));
    endtask

    task automatic update();
        if (reset || mode == M_FLUSH) begin
            e = 0; c = 0; d = 0; mode = M_RUN;
        end else begin
            e += int'(efire);
            c += int'(cfire);
            d += int'(ifire);
            if (mode == M_RUN && bus.flush_req) mode = (c == d) ? M_FLUSH : M_DRAIN;
            else if (mode == M_DRAIN && d == c) mode = M_FLUSH;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_all();
        @(posedge clock);
        update();
        #1;
    endtask

    task automatic drive(input bit dv, input bit cv, input bit fr, input bit rdy, input logic [DEPTH-1:0] rtg);
        bus.disp_valid        = dv;
        bus.commit_valid      = cv;
        bus.flush_req         = fr;
        bus.dcache_req_ready  = rdy;
        bus.entry_ready_to_go = rtg;
    endtask

    initial begin
        logic [DEPTH-1:0] m;
        e = 0; c = 0; d = 0; mode = M_RUN;
        reset = 1'b1;
        drive(1, 1, 0, 1, '1);
        tick();
        tick();
        chk("rst_empty", 32'(bus.sq_empty), 32'd1);

        // Eight dispatches fill the queue, the ninth is refused.
        reset = 1'b0;
        drive(0, 0, 0, 0, '0);
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 0, 0, 0, '0);
            #1 chk("fill_sqidx", 32'(bus.enq_sqidx), 32'(k));
            tick();
        end
        drive(1, 0, 0, 0, '0);
        #1 chk("full_ready", 32'(bus.disp_ready), 32'd0);
        chk("full_count", 32'(bus.sq_count), 32'd8);
        tick();

        // Commit two, issue them, then re-allocate slot 0 with the flag toggled.
        drive(0, 1, 0, 1, '1);
        #1 chk("c0_onehot", 32'(bus.commit_onehot), 32'h1);
        tick();
        drive(0, 1, 0, 1, '1);
        #1 chk("iss0", 32'(bus.issuing_onehot), 32'h1);
        chk("c1_onehot", 32'(bus.commit_onehot), 32'h2);
        tick();
        drive(0, 0, 0, 1, '1);
        #1 chk("iss1", 32'(bus.issuing_onehot), 32'h2);
        tick();
        drive(1, 0, 0, 1, '1);
        #1 chk("wrap_sqidx", 32'(bus.enq_sqidx), 32'h8);
        chk("wrap_count", 32'(bus.sq_count), 32'd6);
        tick();

        // Back-pressure: valid and sel hold, one issuing pulse on accept.
        drive(0, 1, 0, 0, '1);
        tick();
        repeat (3) begin
            drive(0, 0, 0, 0, '1);
            #1 chk("bp_valid", 32'(bus.dcache_req_valid), 32'd1);
            chk("bp_sel", 32'(bus.dcache_req_sel), 32'd2);
            chk("bp_issuing", 32'(bus.issuing_onehot), 32'd0);
            tick();
        end
        drive(0, 0, 0, 1, '1);
        #1 chk("bp_accept", 32'(bus.issuing_onehot), 32'h4);
        tick();
        drive(0, 0, 0, 1, '1);
        #1 chk("bp_done", 32'(bus.dcache_req_valid), 32'd0);
        tick();

        // Five enqueued, three committed, one issued, then flush through DRAIN.
        reset = 1'b1;
        drive(0, 0, 0, 0, '0);
        tick();
        reset = 1'b0;
        tick();
        repeat (5) begin drive(1, 0, 0, 0, '0); tick(); end
        repeat (3) begin drive(0, 1, 0, 0, '0); tick(); end
        drive(0, 0, 0, 1, '1);
        #1 chk("dr_iss0", 32'(bus.issuing_onehot), 32'h1);
        tick();
        drive(1, 0, 1, 0, '1);
        #1 chk("dr_req_ready", 32'(bus.disp_ready), 32'd0);
        tick();
        drive(1, 1, 1, 1, '1);
        #1 chk("dr_iss1", 32'(bus.issuing_onehot), 32'h2);
        chk("dr_nocommit1", 32'(bus.commit_onehot), 32'd0);
        chk("dr_ready1", 32'(bus.disp_ready), 32'd0);
        tick();
        drive(0, 1, 0, 1, '1);
        #1 chk("dr_iss2", 32'(bus.issuing_onehot), 32'h4);
        chk("dr_nocommit2", 32'(bus.commit_onehot), 32'd0);
        chk("dr_noflush", 32'(bus.entry_flush), 32'd0);
        tick();
        drive(0, 1, 0, 1, '1);
        #1 chk("dr_flush", 32'(bus.entry_flush), 32'd1);
        chk("dr_nocommit3", 32'(bus.commit_onehot), 32'd0);
        tick();
        drive(0, 0, 0, 0, '0);
        #1 chk("dr_after_flush", 32'(bus.entry_flush), 32'd0);
        chk("dr_count0", 32'(bus.sq_count), 32'd0);
        chk("dr_sqidx0", 32'(bus.enq_sqidx), 32'd0);
        chk("dr_ready_run", 32'(bus.disp_ready), 32'd1);
        tick();

        // Flush with everything committed already issued goes straight to FLUSH.
        repeat (2) begin drive(1, 0, 0, 1, '1); tick(); end
        repeat (2) begin drive(0, 1, 0, 1, '1); tick(); end
        drive(0, 0, 0, 1, '1);
        tick();
        drive(1, 0, 1, 1, '1);
        #1 chk("fl_req_ready", 32'(bus.disp_ready), 32'd0);
        tick();
        drive(1, 0, 1, 1, '1);
        #1 chk("fl_flush", 32'(bus.entry_flush), 32'd1);
        chk("fl_ready", 32'(bus.disp_ready), 32'd0);
        tick();
        drive(1, 0, 0, 0, '0);
        #1 chk("fl_run_ready", 32'(bus.disp_ready), 32'd1);
        chk("fl_no_reflush", 32'(bus.entry_flush), 32'd0);
        tick();

        // Reset in DRAIN with a request pending abandons it immediately.
        repeat (2) begin drive(1, 0, 0, 0, '0); tick(); end
        repeat (2) begin drive(0, 1, 0, 0, '0); tick(); end
        drive(0, 0, 1, 0, '1);
        tick();
        drive(0, 0, 0, 0, '1);
        #1 chk("rd_valid", 32'(bus.dcache_req_valid), 32'd1);
        bus.dcache_req_ready = 1'b1;
        reset = 1'b1;
        #1 chk("rd_valid0", 32'(bus.dcache_req_valid), 32'd0);
        chk("rd_issuing0", 32'(bus.issuing_onehot), 32'd0);
        chk("rd_count0", 32'(bus.sq_count), 32'd0);
        chk("rd_empty", 32'(bus.sq_empty), 32'd1);
        chk("rd_flush0", 32'(bus.entry_flush), 32'd0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, '0);
        #1 chk("rd_run_ready", 32'(bus.disp_ready), 32'd1);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            m = '0;
            for (int s = d; s < c && s < d + DEPTH; s++) m[s % DEPTH] = 1'b1;
            if ($urandom_range(0, 3) == 0) m = '1;
            drive($urandom_range(0, 9) < 6, ($urandom_range(0, 1) == 1) && (c < e),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, m);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sq_ctrl.md
SQ_CTRL -- requirements
Module: sq_ctrl

Interface
REQ-001 Parameter SQ_DEPTH, default 8, entry count (power of two, >=2).
REQ-002 Parameter SQ_PTR_W, default $clog2(SQ_DEPTH), index width.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  reset; asynchronous, active-high.
REQ-005 disp_valid  in  1  store dispatch request.
REQ-006 disp_ready  out  1  dispatch accepted this cycle.
REQ-007 enq_onehot  out  SQ_DEPTH  per-entry enq_valid strobe.
REQ-008 enq_sqidx  out  SQ_PTR_W+1  {wrap flag, index} allocated to the dispatched store.
REQ-009 commit_valid  in  1  ROB retires the oldest uncommitted store.
REQ-010 commit_onehot  out  SQ_DEPTH  per-entry commit strobe.
REQ-011 entry_ready_to_go  in  SQ_DEPTH  per-entry valid&committed.
REQ-012 dcache_req_valid  out  1; dcache_req_ready  in  1; dcache_req_sel  out  SQ_PTR_W  head index for the data mux.
REQ-013 issuing_onehot  out  SQ_DEPTH  per-entry issuing strobe.
REQ-014 flush_req  in  1  pipeline redirect pulse.
REQ-015 entry_flush  out  1  broadcast flush to all entries.
REQ-016 sq_count  out  SQ_PTR_W+1  occupied entries; sq_empty  out  1.

Function
REQ-017 Three pointers SHALL be kept as {flag, index}: enq_ptr, cmt_ptr, deq_ptr; increment from index SQ_DEPTH-1 wraps to 0 and toggles flag.
REQ-018 full = (enq.index==deq.index) & (enq.flag!=deq.flag); empty = enq_ptr==deq_ptr; sq_count = enq_ptr-deq_ptr modulo 2*SQ_DEPTH.
REQ-019 disp_ready = (state==RUN) & ~full & ~flush_req, from registered state only; an enqueue SHALL NOT use a dequeue in the same cycle to free space.
REQ-020 On disp_valid&disp_ready: enq_onehot[enq.index]=1 same cycle, enq_sqidx=enq_ptr, enq_ptr increments next edge.
REQ-021 In RUN, commit_valid SHALL pulse commit_onehot[cmt.index] same cycle and increment cmt_ptr; commit_valid with cmt_ptr==enq_ptr is illegal (assertion).
REQ-022 dcache_req_valid = entry_ready_to_go[deq.index] & (deq_ptr!=cmt_ptr); dcache_req_sel = deq.index in every cycle.
REQ-023 On dcache_req_valid&dcache_req_ready: issuing_onehot[deq.index]=1 same cycle, deq_ptr increments next edge; at most one issue per cycle; once asserted, dcache_req_valid SHALL stay high until accepted.
REQ-024 Enqueue, commit and issue in one cycle SHALL all take effect.
REQ-025 FSM states RUN, DRAIN, FLUSH.
REQ-026 RUN: flush_req with cmt_ptr==deq_ptr (after this cycle's issue) -> FLUSH; otherwise -> DRAIN; a commit in the same cycle as flush_req SHALL be counted.
REQ-027 DRAIN: commit_valid ignored, issue continues; -> FLUSH in the cycle after deq_ptr reaches cmt_ptr.
REQ-028 FLUSH (exactly one cycle): entry_flush=1, all three pointers cleared to zero at the next edge; -> RUN.
REQ-029 flush_req in DRAIN or FLUSH SHALL be ignored.

Reset
REQ-030 While reset is high: pointers zero, state RUN, all strobes, entry_flush and dcache_req_valid 0, sq_empty 1, sq_count 0; asserting reset mid-issue SHALL abandon the request without an issuing strobe.

Structure
REQ-031 The state enum and the {flag,index} pointer type SHALL live in the shared backend package with SQ_DEPTH.
REQ-032 One sub-module, sq_ptr (wrap-flag pointer with increment and clear), instantiated three times.

Verification
REQ-033 Reset, 8 dispatches with no dispatch in the cycle after reset release -> enq_sqidx 0..7, 9th dispatch disp_ready=0, sq_count=8.
REQ-034 Full queue, commit 2, ready_to_go=all, dcache_req_ready=1 -> issues at index 0,1, deq_ptr=2, next dispatch gets index 0 with flag 1.
REQ-035 dcache_req_ready low 3 cycles -> valid held, sel stable, single issuing pulse on accept.
REQ-036 5 enqueued, 3 committed, 1 issued, flush_req -> DRAIN, 2 further issues, then one-cycle entry_flush, pointers 0, no commit_onehot in between.
REQ-037 Flush with cmt_ptr==deq_ptr -> FLUSH next cycle, disp_ready 0 during flush_req and FLUSH.
REQ-038 Reset asserted during DRAIN -> all outputs at reset values immediately, RUN after release.
